// File: rtl/rib_arbiter.sv
// Round-robin arbiter sharing one RIB slave bus among NUM_MASTERS requesters,
// with a per-transaction watchdog and a combinational stall request for the core.
module rib_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int CORE_IDX    = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    m_req_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*AW-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DW-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic                      m_err_o,
  output logic [DW-1:0]             m_rdata_o,
  output logic                      s_req_o,
  output logic                      s_we_o,
  output logic [AW-1:0]             s_addr_o,
  output logic [DW-1:0]             s_wdata_o,
  input  logic                      s_ack_i,
  input  logic [DW-1:0]             s_rdata_i,
  output logic                      hold_flag_o
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = 16;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_reg;
  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   gnt_idx_reg;
  logic [CW-1:0]   cnt_reg;

  logic [PW-1:0]   sel_idx;
  logic [PW-1:0]   ptr_next;
  logic            busy;
  logic            gnt_req;
  logic            timeout_hit;
  logic            ack_fire;

  logic [AW-1:0]   addr_arr  [NUM_MASTERS];
  logic [DW-1:0]   wdata_arr [NUM_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign addr_arr[gi]  = m_addr_i[gi*AW +: AW];
      assign wdata_arr[gi] = m_wdata_i[gi*DW +: DW];
      assign m_ack_o[gi]   = ack_fire && (gnt_idx_reg == PW'(gi));
    end
  endgenerate

  // Scan downward so the requester closest to ptr (smallest offset) wins last.
  always_comb begin
    logic [PW-1:0] cand;
    cand    = '0;
    sel_idx = ptr_reg;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      cand = PW'((int'(ptr_reg) + i) % NUM_MASTERS);
      if (m_req_i[cand]) sel_idx = cand;
    end
  end

  assign busy        = (state_reg == BUSY);
  assign gnt_req     = m_req_i[gnt_idx_reg];
  assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));
  // A dropped request abandons the transaction silently; reset suppresses completion.
  assign ack_fire    = busy && gnt_req && !rst && (s_ack_i || timeout_hit);
  assign ptr_next    = (gnt_idx_reg == PW'(NUM_MASTERS - 1)) ? '0 : gnt_idx_reg + PW'(1);

  assign s_req_o   = busy;
  assign s_we_o    = busy && m_we_i[gnt_idx_reg];
  assign s_addr_o  = busy ? addr_arr[gnt_idx_reg]  : '0;
  assign s_wdata_o = busy ? wdata_arr[gnt_idx_reg] : '0;

  assign m_err_o   = ack_fire && !s_ack_i;
  assign m_rdata_o = (ack_fire && s_ack_i) ? s_rdata_i : '0;

  assign hold_flag_o = m_req_i[CORE_IDX] &&
                       !(busy && (gnt_idx_reg == PW'(CORE_IDX)) && m_ack_o[CORE_IDX]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      gnt_idx_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|m_req_i) begin
            gnt_idx_reg <= sel_idx;
            cnt_reg     <= '0;
            state_reg   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_reg != '1) cnt_reg <= cnt_reg + CW'(1);
          if (!gnt_req) begin
            state_reg <= IDLE;
          end else if (ack_fire) begin
            ptr_reg   <= ptr_next;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed, table-driven bench for rib_arbiter (4 masters, TIMEOUT=4, core on index 0).
module tb_rib_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_req_i;
  logic [N-1:0]    m_we_i;
  logic [N*AW-1:0] m_addr_i;
  logic [N*DW-1:0] m_wdata_i;
  logic [N-1:0]    m_ack_o;
  logic            m_err_o;
  logic [DW-1:0]   m_rdata_o;
  logic            s_req_o;
  logic            s_we_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW-1:0]   s_wdata_o;
  logic            s_ack_i;
  logic [DW-1:0]   s_rdata_i;
  logic            hold_flag_o;

  always #5 clk = ~clk;

  assign m_we_i    = 4'b1010;
  assign m_addr_i  = {32'h0000_0300, 32'h0000_1000, 32'h0000_0200, 32'h0000_0100};
  assign m_wdata_i = {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0};

  rib_arbiter #(
    .NUM_MASTERS(N), .AW(AW), .DW(DW), .CORE_IDX(0), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rdata_o(m_rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_ack_i(s_ack_i), .s_rdata_i(s_rdata_i), .hold_flag_o(hold_flag_o)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        sack;
    logic [31:0] srd;
    logic        sreq;
    logic [31:0] addr;
    logic        swe;
    logic [3:0]  ack;
    logic        err;
    logic [31:0] mrd;
    logic        hold;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic r, logic [3:0] rq, logic sa, logic [31:0] sd,
                              logic sr, logic [31:0] ad, logic we, logic [3:0] ak,
                              logic er, logic [31:0] md, logic hd);
    vec_t v;
    v.rst = r; v.req = rq; v.sack = sa; v.srd = sd;
    v.sreq = sr; v.addr = ad; v.swe = we; v.ack = ak; v.err = er; v.mrd = md; v.hold = hd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    bit  seen;

    rst = 1'b1; m_req_i = '0; s_ack_i = 1'b0; s_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;

    // rst req sack srd | sreq addr we ack err mrd hold
    vq.push_back(mk(1, 4'b0000, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        0));
    vq.push_back(mk(0, 4'b0000, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        0));
    // master 2 read, ack in second BUSY cycle
    vq.push_back(mk(0, 4'b0100, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        0));
    vq.push_back(mk(0, 4'b0100, 0, 32'h0,        1, 32'h1000, 0, 4'b0000, 0, 32'h0,        0));
    vq.push_back(mk(0, 4'b0100, 1, 32'hDEADBEEF, 1, 32'h1000, 0, 4'b0100, 0, 32'hDEADBEEF, 0));
    vq.push_back(mk(0, 4'b0000, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        0));
    // reset, then all four request continuously: grant order 0,1,2,3,0
    vq.push_back(mk(1, 4'b0000, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        0));
    vq.push_back(mk(0, 4'b1111, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        1));
    vq.push_back(mk(0, 4'b1111, 1, 32'h11,       1, 32'h100,  0, 4'b0001, 0, 32'h11,       0));
    vq.push_back(mk(0, 4'b1111, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        1));
    vq.push_back(mk(0, 4'b1111, 1, 32'h22,       1, 32'h200,  1, 4'b0010, 0, 32'h22,       1));
    vq.push_back(mk(0, 4'b1111, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        1));
    vq.push_back(mk(0, 4'b1111, 1, 32'h33,       1, 32'h1000, 0, 4'b0100, 0, 32'h33,       1));
    vq.push_back(mk(0, 4'b1111, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        1));
    vq.push_back(mk(0, 4'b1111, 1, 32'h44,       1, 32'h300,  1, 4'b1000, 0, 32'h44,       1));
    vq.push_back(mk(0, 4'b1111, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        1));
    vq.push_back(mk(0, 4'b1111, 1, 32'h55,       1, 32'h100,  0, 4'b0001, 0, 32'h55,       0));
    // master 0, slave silent: abort in the 4th BUSY cycle
    vq.push_back(mk(0, 4'b0001, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        1));
    vq.push_back(mk(0, 4'b0001, 0, 32'h0,        1, 32'h100,  0, 4'b0000, 0, 32'h0,        1));
    vq.push_back(mk(0, 4'b0001, 0, 32'h0,        1, 32'h100,  0, 4'b0000, 0, 32'h0,        1));
    vq.push_back(mk(0, 4'b0001, 0, 32'h0,        1, 32'h100,  0, 4'b0000, 0, 32'h0,        1));
    vq.push_back(mk(0, 4'b0001, 0, 32'h99,       1, 32'h100,  0, 4'b0001, 1, 32'h0,        0));
    // ptr is now 1: masters 0 and 1 request, 1 wins
    vq.push_back(mk(0, 4'b0011, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        1));
    vq.push_back(mk(0, 4'b0011, 1, 32'h66,       1, 32'h200,  1, 4'b0010, 0, 32'h66,       1));
    // master 3 holds the bus 3 cycles while the core waits; ptr wraps 3 -> 0
    vq.push_back(mk(0, 4'b1000, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        0));
    vq.push_back(mk(0, 4'b1001, 0, 32'h0,        1, 32'h300,  1, 4'b0000, 0, 32'h0,        1));
    vq.push_back(mk(0, 4'b1001, 0, 32'h0,        1, 32'h300,  1, 4'b0000, 0, 32'h0,        1));
    vq.push_back(mk(0, 4'b1001, 1, 32'h77,       1, 32'h300,  1, 4'b1000, 0, 32'h77,       1));
    vq.push_back(mk(0, 4'b0001, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        1));
    vq.push_back(mk(0, 4'b0001, 1, 32'h88,       1, 32'h100,  0, 4'b0001, 0, 32'h88,       0));
    // reset mid-BUSY (ptr 1 -> granted 2), then ptr=0 picks master 0 over 2
    vq.push_back(mk(0, 4'b0100, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        0));
    vq.push_back(mk(0, 4'b0100, 0, 32'h0,        1, 32'h1000, 0, 4'b0000, 0, 32'h0,        0));
    vq.push_back(mk(1, 4'b0100, 1, 32'hAB,       1, 32'h1000, 0, 4'b0000, 0, 32'h0,        0));
    vq.push_back(mk(0, 4'b0101, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        1));
    vq.push_back(mk(0, 4'b0101, 1, 32'hC0,       1, 32'h100,  0, 4'b0001, 0, 32'hC0,       0));
    // s_ack_i while IDLE is ignored
    vq.push_back(mk(0, 4'b0000, 1, 32'hEE,       0, 32'h0,    0, 4'b0000, 0, 32'h0,        0));
    vq.push_back(mk(0, 4'b0000, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        0));
    // ack coincides with the timeout cycle: ack wins
    vq.push_back(mk(0, 4'b0010, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        0));
    vq.push_back(mk(0, 4'b0010, 0, 32'h0,        1, 32'h200,  1, 4'b0000, 0, 32'h0,        0));
    vq.push_back(mk(0, 4'b0010, 0, 32'h0,        1, 32'h200,  1, 4'b0000, 0, 32'h0,        0));
    vq.push_back(mk(0, 4'b0010, 0, 32'h0,        1, 32'h200,  1, 4'b0000, 0, 32'h0,        0));
    vq.push_back(mk(0, 4'b0010, 1, 32'h5A5A,     1, 32'h200,  1, 4'b0010, 0, 32'h5A5A,     0));
    // granted master 2 drops its request: no ack, ptr stays 2
    vq.push_back(mk(0, 4'b0100, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        0));
    vq.push_back(mk(0, 4'b0000, 0, 32'h0,        1, 32'h1000, 0, 4'b0000, 0, 32'h0,        0));
    vq.push_back(mk(0, 4'b0110, 0, 32'h0,        0, 32'h0,    0, 4'b0000, 0, 32'h0,        0));
    vq.push_back(mk(0, 4'b0110, 1, 32'h31,       1, 32'h1000, 0, 4'b0100, 0, 32'h31,       0));

    foreach (vq[i]) begin
      rst = vq[i].rst; m_req_i = vq[i].req; s_ack_i = vq[i].sack; s_rdata_i = vq[i].srd;
      @(negedge clk);
      chk($sformatf("v%0d_sreq", i),  s_req_o,     vq[i].sreq);
      chk($sformatf("v%0d_addr", i),  s_addr_o,    vq[i].addr);
      chk($sformatf("v%0d_swe", i),   s_we_o,      vq[i].swe);
      chk($sformatf("v%0d_ack", i),   m_ack_o,     vq[i].ack);
      chk($sformatf("v%0d_err", i),   m_err_o,     vq[i].err);
      chk($sformatf("v%0d_rdata", i), m_rdata_o,   vq[i].mrd);
      chk($sformatf("v%0d_hold", i),  hold_flag_o, vq[i].hold);
      $display("vec %0d rst=%b req=%b sack=%b -> sreq=%b addr=%h we=%b ack=%b err=%b rdata=%h hold=%b",
               i, rst, m_req_i, s_ack_i, s_req_o, s_addr_o, s_we_o, m_ack_o, m_err_o,
               m_rdata_o, hold_flag_o);
      @(posedge clk);
      #1;
    end

    // ptr is 3: master 3 alone with a silent slave, ack must land 4 cycles after the IDLE cycle
    rst = 1'b0; m_req_i = 4'b1000; s_ack_i = 1'b0; s_rdata_i = 32'h99;
    n = 0; seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      if (m_ack_o != '0) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("to_seen",  32'(seen), 32'd1);
    chk("to_cycle", n, 4);
    chk("to_ack",   m_ack_o, 4'b1000);
    chk("to_err",   m_err_o, 1'b1);
    chk("to_rdata", m_rdata_o, 32'h0);
    $display("seq timeout master3 cycles=%0d ack=%b err=%b", n, m_ack_o, m_err_o);
    @(posedge clk);
    #1;
    m_req_i = 4'b1001;
    @(negedge clk);
    chk("wrap_idle_sreq", s_req_o, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("wrap_grant_addr", s_addr_o, 32'h100);
    $display("seq wrap grant addr=%h", s_addr_o);
    @(posedge clk);
    #1;
    m_req_i = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rib_arbiter.md
# rib_arbiter

Round-robin arbiter that shares the single RIB slave-side bus among up to NUM_MASTERS requesters: core data port, JTAG debug module and DMA-style peripherals. It registers one grant per transaction and muxes the winner's address and write data onto the slave bus. It routes the slave's response back to the winner and aborts stalled transactions with a watchdog. It also produces the `hold_flag_rib` request consumed by the pipeline control block, so the core stalls while its data port waits for the bus.

## Interface
Parameters:
- NUM_MASTERS, 4: number of requesters; 2..8.
- AW, 32: address width.
- DW, 32: data width.
- CORE_IDX, 0: index of the core data master that drives `hold_flag_o`.
- TIMEOUT, 255: cycles a granted transaction may wait for `s_ack_i`; 1..65535.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- m_req_i  in  NUM_MASTERS  per-master request, held until that master's ack.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_addr_i  in  NUM_MASTERS*AW  packed addresses; master k occupies bits [k*AW +: AW].
- m_wdata_i  in  NUM_MASTERS*DW  packed write data, same packing as addresses.
- m_ack_o  out  NUM_MASTERS  one-cycle completion pulse to the winner.
- m_err_o  out  1  qualifies `m_ack_o`; 1 = timeout abort.
- m_rdata_o  out  DW  read data, shared by all masters; valid with `m_ack_o`.
- s_req_o  out  1  slave-side request.
- s_we_o  out  1  slave-side write enable.
- s_addr_o  out  AW  slave-side address.
- s_wdata_o  out  DW  slave-side write data.
- s_ack_i  in  1  slave completion, single cycle.
- s_rdata_i  in  DW  slave read data, valid with `s_ack_i`.
- hold_flag_o  out  1  stall request to the pipeline control block.

## Operation
- State machine with two states: IDLE and BUSY.
- Priority pointer `ptr` is an index of width clog2(NUM_MASTERS). It resets to 0.
- IDLE:
  - If any `m_req_i` bit is set, select the first requesting index, scanning from `ptr` upward with wrap-around.
  - Register the selection into `gnt_idx`, clear the watchdog counter and go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - `s_req_o`=1. `s_we_o`, `s_addr_o` and `s_wdata_o` are the slices of master `gnt_idx`, muxed combinationally.
  - The watchdog counter increments by 1 each BUSY cycle and saturates.
  - On `s_ack_i`=1: `m_ack_o[gnt_idx]`=1 and `m_err_o`=0 in the same cycle, and `m_rdata_o`=`s_rdata_i`. Then `ptr` ← (`gnt_idx`+1) mod NUM_MASTERS and the state goes to IDLE.
  - On timeout (counter == TIMEOUT-1 and `s_ack_i`=0): `m_ack_o[gnt_idx]`=1, `m_err_o`=1 and `m_rdata_o`=0. Then `ptr` advances and the state goes to IDLE, as on an ack.
  - `s_ack_i` and timeout in the same cycle: the ack wins and `m_err_o`=0.
  - Granted master drops `m_req_i` before any ack: state goes to IDLE next cycle with no `m_ack_o` and no `ptr` update. `s_req_o` stays 1 during the cycle the drop is seen.
- `s_ack_i` is ignored in IDLE; no ack is forwarded.
- When no ack is being forwarded, `m_rdata_o`=0 and `m_err_o`=0.
- `hold_flag_o` = `m_req_i[CORE_IDX]` & ~(BUSY & `gnt_idx`==CORE_IDX & `m_ack_o[CORE_IDX]`). This is combinational, so the core stalls in every waiting cycle and releases in its ack cycle.
- Outputs of non-winning masters are always 0.

## Timing
- Reset values: state=IDLE, `ptr`=0, `gnt_idx`=0, counter=0. All outputs are 0, except `hold_flag_o`, which follows its equation.
- Reset asserted in BUSY: the next cycle is IDLE with no ack and `s_req_o`=0. The interrupted master keeps its request and re-arbitrates.
- Latency:
  - Request seen at cycle t gives `s_req_o`=1 at t+1.
  - The earliest `m_ack_o` is at t+1, if the slave acks combinationally.
- There is one mandatory IDLE bubble between back-to-back transactions, so maximum throughput is one transaction per 2 cycles.
- A timeout abort occurs in BUSY cycle TIMEOUT, counting from 1.
- `ptr` wraps from NUM_MASTERS-1 to 0.

## Test plan
- Single master 2 requests a read of addr 0x1000; the slave acks in the second BUSY cycle with 0xDEADBEEF. Required: `s_addr_o`=0x1000, `m_ack_o`=4'b0100, `m_rdata_o`=0xDEADBEEF, `m_err_o`=0, followed by 1 IDLE cycle.
- All 4 masters request continuously and the slave acks in the same cycle each time. Required: grant order 0,1,2,3,0, each transaction 2 cycles, no starvation.
- Master 0 requests and the slave never acks, with TIMEOUT=4. Required: `m_ack_o[0]`=1 and `m_err_o`=1 in the 4th BUSY cycle, `m_rdata_o`=0, then `ptr`=1.
- CORE_IDX=0 requests while master 3 holds the bus for 3 cycles. Required: `hold_flag_o`=1 throughout; it drops in the core's ack cycle.
- Reset asserted mid-BUSY, and separately `s_ack_i` pulsed while IDLE. Required: in both cases no `m_ack_o`, `s_req_o`=0 in the following cycle, `ptr`=0 after reset.
- `s_ack_i` coincides with the timeout cycle. Required: `m_err_o`=0 and `m_rdata_o`=`s_rdata_i`.
